// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared constants and width helper for the digit scan controller
package digit_scan_pkg;
  localparam logic ANODE_OFF = 1'b1;
  localparam int DIGIT_ZERO = 0;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running 0..DIV-1 counter exposing its next value and terminal count
module refresh_prescaler #(
  parameter int DIV = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] next,
  output logic         tc
);
  logic [W-1:0] count;
  assign tc = count == W'(DIV - 1);
  assign next = !en ? count : tc ? '0 : count + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= next;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed display scanner with per-frame snapshot, enable mask and blanking
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_W      = 5,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_flat,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [DIGIT_W-1:0]            out_digit,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);
  localparam int IDX_W   = width_of(NUM_DIGITS);
  localparam int PRESC_W = width_of(REFRESH_DIV);
  logic                  load_pend;
  logic [PRESC_W-1:0]    presc_nx;
  logic                  tc;
  logic                  last;
  logic                  snap;
  logic                  lit;
  logic [IDX_W-1:0]      idx_nx;
  logic [DIGIT_W-1:0]    shadow_dig [NUM_DIGITS];
  logic [DIGIT_W-1:0]    dig_nx     [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_en, en_nx, lz_nx, anode_nx;
  refresh_prescaler #(.DIV(REFRESH_DIV), .W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!load_pend),
    .next (presc_nx),
    .tc   (tc)
  );
  assign last = digit_idx == IDX_W'(NUM_DIGITS - 1);
  assign snap = load_pend || (tc && last);
  assign idx_nx = load_pend ? '0 : !tc ? digit_idx : last ? '0 : digit_idx + 1'b1;
  assign en_nx = snap ? digit_en : shadow_en;
  always_comb
    for (int i = 0; i < NUM_DIGITS; i++)
      dig_nx[i] = snap ? digits_flat[i*DIGIT_W +: DIGIT_W] : shadow_dig[i];
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_in, shadow_lz;
  logic                  zrun;
  // Walk down from the most significant digit; digit 0 is never suppressed.
  always_comb begin
    lz_in = '0;
    zrun = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun = zrun && (digits_flat[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(DIGIT_ZERO));
      lz_in[i] = zrun;
    end
  end
  assign lz_nx = snap ? lz_in : shadow_lz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow_lz <= '0;
    else shadow_lz <= lz_nx;
`else
  assign lz_nx = '0;
`endif
  assign lit = int'(presc_nx) >= BLANK_CYCLES && en_nx[idx_nx] && !lz_nx[idx_nx];
  always_comb begin
    anode_nx = {NUM_DIGITS{ANODE_OFF}};
    anode_nx[idx_nx] = !lit;
  end
  // Outputs are registered from next-state values so they align with the counters.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load_pend   <= 1'b1;
      digit_idx   <= '0;
      anode_n     <= {NUM_DIGITS{ANODE_OFF}};
      out_digit   <= '0;
      frame_start <= 1'b0;
      shadow_en   <= '0;
      shadow_dig  <= '{default: '0};
    end else begin
      load_pend   <= 1'b0;
      digit_idx   <= idx_nx;
      anode_n     <= anode_nx;
      out_digit   <= dig_nx[idx_nx];
      frame_start <= presc_nx == '0 && idx_nx == '0;
      shadow_en   <= en_nx;
      shadow_dig  <= dig_nx;
    end
endmodule
